// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double-buffered load.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg7_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg7_scan_driver: BLINK_FRAMES must be >= 1");
  end

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     data_pend_q, data_pend_d, data_act_q, data_act_d;
  logic [DIGITS-1:0] blank_pend_q, blank_pend_d, blank_act_q, blank_act_d;
  logic              lz_pend_q, lz_pend_d, lz_act_q, lz_act_d;
  logic              pend_q, pend_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              tick_q, tick_d;
  logic              boundary_c;
  logic              blink_blank_c;
  logic [DIGITS-1:0] blink_vec_c;

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [DIGITS-1:0] blink_pend_q, blink_pend_d, blink_act_q, blink_act_d;
  logic [BW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;

  // Blink mask double buffer and frame-counted blink phase
  always_comb begin
    blink_pend_d = blink_pend_q;
    blink_act_d  = blink_act_q;
    fcnt_d       = fcnt_q;
    phase_d      = phase_q;
    if (load) blink_pend_d = blink_mask;
    if (boundary_c) begin
      if (load)        blink_act_d = blink_mask;
      else if (pend_q) blink_act_d = blink_pend_q;
      if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_pend_q <= '0;
      blink_act_q  <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
    end else begin
      blink_pend_q <= blink_pend_d;
      blink_act_q  <= blink_act_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
    end
  end

  assign blink_vec_c = phase_q ? blink_act_q : '0;
`else
  assign blink_vec_c = '0;
`endif

  assign boundary_c = (idx_q == IW'(DIGITS - 1)) && (presc_q == PW'(SCAN_DIV - 1));

  logic [DIGITS-1:0] lz_vec;
  logic              zero_above;
  logic [3:0]        nib;
  logic              blk;
  logic [DIGITS-1:0] an_sel;

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    data_pend_d  = data_pend_q;
    blank_pend_d = blank_pend_q;
    lz_pend_d    = lz_pend_q;
    pend_d       = pend_q;
    data_act_d   = data_act_q;
    blank_act_d  = blank_act_q;
    lz_act_d     = lz_act_q;
    lz_vec       = '0;
    zero_above   = 1'b1;
    nib          = 4'h0;
    blk          = 1'b0;
    blink_blank_c = 1'b0;
    an_sel       = '1;

    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (load) begin
      data_pend_d  = data;
      blank_pend_d = blank_mask;
      lz_pend_d    = lz_en;
      pend_d       = 1'b1;
    end

    // A load landing on the boundary bypasses the pending copy
    if (boundary_c) begin
      if (load) begin
        data_act_d  = data;
        blank_act_d = blank_mask;
        lz_act_d    = lz_en;
      end else if (pend_q) begin
        data_act_d  = data_pend_q;
        blank_act_d = blank_pend_q;
        lz_act_d    = lz_pend_q;
      end
      pend_d = 1'b0;
    end

    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (data_act_q[4*i +: 4] == 4'h0);
      lz_vec[i]  = lz_act_q & zero_above & (i != 0);
    end

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib           = data_act_q[4*i +: 4];
        blink_blank_c = blink_vec_c[i];
        blk           = blank_act_q[i] | lz_vec[i] | blink_blank_c;
        an_sel[i]     = 1'b0;
      end
    end

    // Prescaler 0 is the dead cycle between digits
    seg_d  = (presc_q == '0 || blk) ? 7'b1111111 : hex_decode(nib);
    an_d   = (presc_q == '0) ? '1 : an_sel;
    tick_d = boundary_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      data_pend_q  <= '0;
      blank_pend_q <= '0;
      lz_pend_q    <= 1'b0;
      pend_q       <= 1'b0;
      data_act_q   <= '0;
      blank_act_q  <= '0;
      lz_act_q     <= 1'b0;
      seg_q        <= 7'b1111111;
      an_q         <= '1;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      data_pend_q  <= data_pend_d;
      blank_pend_q <= blank_pend_d;
      lz_pend_q    <= lz_pend_d;
      pend_q       <= pend_d;
      data_act_q   <= data_act_d;
      blank_act_q  <= blank_act_d;
      lz_act_q     <= lz_act_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4): frame-position
// model checked every cycle plus directed literal expectations.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int FRAME = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = 4'b0000;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .blank_mask(blank_mask),
    .lz_en(lz_en),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: m_cyc = clock edges since reset release; position in frame decides outputs
  int          m_cyc;
  logic [15:0] m_pd, m_ad;
  logic [3:0]  m_pb, m_ab;
  logic        m_pl, m_al, m_pf;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_tick;

  function automatic logic [6:0] m_seg(int cyc, logic [15:0] d, logic [3:0] bm, logic lz);
    int p, dig;
    logic [15:0] upper;
    p   = cyc % FRAME;
    dig = p / SCAN_DIV;
    upper = d >> (4 * dig);
    if (p % SCAN_DIV == 0) return 7'b1111111;
    if (bm[dig]) return 7'b1111111;
    if (lz && dig != 0 && upper == 16'h0) return 7'b1111111;
    return dec_tab[upper[3:0]];
  endfunction

  function automatic logic [3:0] m_an(int cyc);
    int p;
    logic [3:0] r;
    p = cyc % FRAME;
    r = 4'b1111;
    if (p % SCAN_DIV != 0) r[p / SCAN_DIV] = 1'b0;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0; m_pd <= '0; m_ad <= '0; m_pb <= '0; m_ab <= '0;
      m_pl <= 1'b0; m_al <= 1'b0; m_pf <= 1'b0;
      exp_seg <= 7'b1111111; exp_an <= 4'b1111; exp_tick <= 1'b0;
    end else begin
      exp_seg  <= m_seg(m_cyc, m_ad, m_ab, m_al);
      exp_an   <= m_an(m_cyc);
      exp_tick <= (m_cyc % FRAME == FRAME - 1);
      m_cyc    <= m_cyc + 1;
      if (load) begin
        m_pd <= data; m_pb <= blank_mask; m_pl <= lz_en; m_pf <= 1'b1;
      end
      if (m_cyc % FRAME == FRAME - 1) begin
        if (load) begin
          m_ad <= data; m_ab <= blank_mask; m_al <= lz_en;
        end else if (m_pf) begin
          m_ad <= m_pd; m_ab <= m_pb; m_al <= m_pl;
        end
        m_pf <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (seg !== exp_seg) begin
        errors++;
        $display("FAIL model_seg t=%0t got %b want %b", $time, seg, exp_seg);
      end
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL model_an t=%0t got %b want %b", $time, an, exp_an);
      end
      checks++;
      if (frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL model_tick t=%0t got %b want %b", $time, frame_tick, exp_tick);
      end
    end
  end

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] bm, input logic lz);
    @(posedge clk); #1;
    load = 1'b1; data = d; blank_mask = bm; lz_en = lz;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_tick && n < 3 * FRAME);
    if (!frame_tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout got none want pulse");
    end
  endtask

  task automatic expect_digit(input logic [3:0] a, input logic [6:0] s, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== a && n < 3 * FRAME);
    if (an !== a) begin
      checks++; errors++;
      $display("FAIL %s_timeout an got %b want %b", name, an, a);
    end else begin
      check_val(name, {1'b0, seg}, {1'b0, s});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; data = '0; blank_mask = '0; lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check_val("reset_seg", {1'b0, seg}, 8'h7f);
    check_val("reset_an", {4'h0, an}, 8'h0f);
    check_val("reset_tick", {7'h0, frame_tick}, 8'h00);
    expect_digit(4'b1110, 7'b1000000, "first_digit");

    // Hex decode
    do_load(16'hA5C3, 4'b0000, 1'b0);
    wait_tick(); wait_tick();
    expect_digit(4'b1110, 7'b0110000, "hex_d0");
    expect_digit(4'b1101, 7'b1000110, "hex_d1");
    expect_digit(4'b1011, 7'b0010010, "hex_d2");
    expect_digit(4'b0111, 7'b0001000, "hex_d3");
    wait_tick();
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_tick && n < 40);
    check_val("tick_period", 8'(n), 8'(FRAME));

    // Leading-zero suppression
    do_load(16'h0007, 4'b0000, 1'b1);
    wait_tick(); wait_tick();
    expect_digit(4'b1110, 7'b1111000, "lz7_d0");
    expect_digit(4'b1101, 7'b1111111, "lz7_d1");
    expect_digit(4'b1011, 7'b1111111, "lz7_d2");
    expect_digit(4'b0111, 7'b1111111, "lz7_d3");
    do_load(16'h0000, 4'b0000, 1'b1);
    wait_tick(); wait_tick();
    expect_digit(4'b1110, 7'b1000000, "lz0_d0");
    expect_digit(4'b1101, 7'b1111111, "lz0_d1");
    do_load(16'h0000, 4'b0000, 1'b0);
    wait_tick(); wait_tick();
    expect_digit(4'b0111, 7'b1000000, "nolz_d3");

    // Double buffer: mid-frame loads hold until the boundary
    wait_tick();
    repeat (5) @(posedge clk);
    do_load(16'h1111, 4'b0000, 1'b0);
    do_load(16'h2222, 4'b0000, 1'b0);
    expect_digit(4'b0111, 7'b1000000, "db_old_d3");
    expect_digit(4'b1110, 7'b0100100, "db_new_d0");
    expect_digit(4'b1101, 7'b0100100, "db_new_d1");
    expect_digit(4'b0111, 7'b0100100, "db_new_d3");

    // Load exactly in the boundary cycle
    do_load(16'h3333, 4'b0000, 1'b0);
    wait_tick(); wait_tick(); wait_tick();
    repeat (FRAME - 1) @(posedge clk);
    #1 load = 1'b1; data = 16'h4444;
    @(posedge clk); #1 load = 1'b0;
    expect_digit(4'b1110, 7'b0011001, "bnd_load_d0");

    // Blank mask and dead time
    do_load(16'h8888, 4'b0100, 1'b0);
    wait_tick(); wait_tick();
    expect_digit(4'b1011, 7'b1111111, "blank_d2");
    expect_digit(4'b0111, 7'b0000000, "blank_d3");
    wait_tick();
    check_val("tick_an_d3", {4'h0, an}, 8'h07);
    @(negedge clk);
    check_val("dead_an", {4'h0, an}, 8'h0f);
    check_val("dead_seg", {1'b0, seg}, 8'h7f);

    // Async reset mid-frame discards a pending load
    wait_tick();
    repeat (2) @(negedge clk);
    do_load(16'h9999, 4'b0000, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check_val("mid_rst_seg", {1'b0, seg}, 8'h7f);
    check_val("mid_rst_an", {4'h0, an}, 8'h0f);
    check_val("mid_rst_tick", {7'h0, frame_tick}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (an === 4'b1111 && n < 10);
    check_val("post_rst_an", {4'h0, an}, 8'h0e);
    check_val("post_rst_seg", {1'b0, seg}, 8'h40);
    wait_tick(); wait_tick();
    expect_digit(4'b1110, 7'b1000000, "rst_discard_d0");

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
